// File: rtl/multi_alarm_clock.sv
// -----------------------------------------------------------------------------
// multi_alarm_clock
//
// Time-of-day clock (HH:MM:SS) with NUM_ALARMS programmable alarm slots and a
// ringing state machine offering snooze, stop and automatic ring timeout.
//
// Ports
//   clk, rst     : single clock, synchronous active-high reset
//   set_valid    : write request (time or alarm slot)
//   set_ready    : low only while the prescaler sits at its terminal count
//   set_target   : 0..NUM_ALARMS-1 selects an alarm slot, NUM_ALARMS the time
//   set_hour     : hour to load (0..23)
//   set_min      : minute to load (0..59)
//   set_en       : slot enable to load (ignored for time writes)
//   set_err      : one-cycle pulse after a rejected (out-of-range) write
//   snooze, stop : single-cycle user pulses, already debounced
//   tick         : one-cycle pulse, coincident with the new time value
//   hour/min/sec : current time of day
//   alarm_on     : high while RINGING
//   alarm_idx    : slot that caused the current or most recent ring
//   state        : 0 = IDLE, 1 = RINGING, 2 = SNOOZED
// -----------------------------------------------------------------------------
module multi_alarm_clock #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TICK_FREQ  = 1,
  parameter int NUM_ALARMS = 4,
  parameter int INIT_HOUR  = 0,
  parameter int INIT_MIN   = 0,
  parameter int ALARM_HOUR = 7,
  parameter int ALARM_MIN  = 30,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 10,
  localparam int AW        = $clog2(NUM_ALARMS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_valid,
  output logic          set_ready,
  input  logic [AW-1:0] set_target,
  input  logic [4:0]    set_hour,
  input  logic [5:0]    set_min,
  input  logic          set_en,
  output logic          set_err,
  input  logic          snooze,
  input  logic          stop,
  output logic          tick,
  output logic [4:0]    hour,
  output logic [5:0]    min,
  output logic [5:0]    sec,
  output logic          alarm_on,
  output logic [AW-1:0] alarm_idx,
  output logic [1:0]    state
);

  localparam int DIV     = CLK_FREQ / TICK_FREQ;
  localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_MAX = (RING_MIN > SNOOZE_MIN) ? RING_MIN : SNOOZE_MIN;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [AW-1:0] TIME_TGT   = AW'(NUM_ALARMS);
  localparam logic [CW-1:0] RING_LOAD  = CW'(RING_MIN);
  localparam logic [CW-1:0] SNZ_LOAD   = CW'(SNOOZE_MIN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RING = 2'd1,
    S_SNZ  = 2'd2
  } state_t;

  // Minute counters never go below zero; a boundary seen at zero stays at zero.
  function automatic logic [CW-1:0] dec_sat(input logic [CW-1:0] v);
    return (v == '0) ? '0 : v - CW'(1);
  endfunction

  // Modulo increment used for every field of the time-of-day counter.
  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] last);
    return (v == last) ? 6'd0 : v + 6'd1;
  endfunction

  logic [PW-1:0] presc_p0;
  logic          presc_last;

  logic [4:0]    hour_p1;
  logic [5:0]    min_p1;
  logic [5:0]    sec_p1;
  logic          vld_p1;

  logic [4:0]    slot_hour [NUM_ALARMS];
  logic [5:0]    slot_min  [NUM_ALARMS];
  logic          slot_en   [NUM_ALARMS];

  logic          wr_acc;
  logic          wr_bad;
  logic          wr_time;
  logic          wr_slot;
  logic [5:0]    hour_inc;

  logic          bnd_p1;
  logic          hit_p1;
  logic [AW-1:0] win_p1;

  state_t        state_r;
  state_t        state_nxt;
  logic [CW-1:0] ring_cnt;
  logic [CW-1:0] ring_nxt;
  logic [CW-1:0] snz_cnt;
  logic [CW-1:0] snz_nxt;
  logic [AW-1:0] idx_nxt;

  // ---------------------------------------------------------------------------
  // Stage p0: prescaler and write-port decode
  // ---------------------------------------------------------------------------
  assign presc_last = (presc_p0 == PRESC_LAST);
  // Refusing writes on the terminal count keeps a load from racing an increment.
  assign set_ready  = ~presc_last;
  assign wr_acc     = set_valid & set_ready;
  assign wr_bad     = (set_hour > 5'd23) || (set_min > 6'd59) || (set_target > TIME_TGT);
  assign wr_time    = wr_acc & ~wr_bad & (set_target == TIME_TGT);
  assign wr_slot    = wr_acc & ~wr_bad & (set_target != TIME_TGT);
  assign hour_inc   = inc_wrap({1'b0, hour_p1}, 6'd23);

  // ---------------------------------------------------------------------------
  // Stage p1: registered time of day, tick and write error
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_p0 <= '0;
      hour_p1  <= 5'(INIT_HOUR);
      min_p1   <= 6'(INIT_MIN);
      sec_p1   <= '0;
      vld_p1   <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      set_err <= wr_acc & wr_bad;
      if (wr_time) begin
        // A time load restarts the current second and never raises tick.
        presc_p0 <= '0;
        hour_p1  <= set_hour;
        min_p1   <= set_min;
        sec_p1   <= '0;
        vld_p1   <= 1'b0;
      end else if (presc_last) begin
        presc_p0 <= '0;
        vld_p1   <= 1'b1;
        sec_p1   <= inc_wrap(sec_p1, 6'd59);
        if (sec_p1 == 6'd59) begin
          min_p1 <= inc_wrap(min_p1, 6'd59);
          if (min_p1 == 6'd59) begin
            hour_p1 <= hour_inc[4:0];
          end
        end
      end else begin
        presc_p0 <= presc_p0 + PW'(1);
        vld_p1   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_hour[i] <= (i == 0) ? 5'(ALARM_HOUR) : 5'd0;
        slot_min[i]  <= (i == 0) ? 6'(ALARM_MIN) : 6'd0;
        slot_en[i]   <= (i == 0);
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (wr_slot && (set_target == AW'(i))) begin
          slot_hour[i] <= set_hour;
          slot_min[i]  <= set_min;
          slot_en[i]   <= set_en;
        end
      end
    end
  end

  assign tick = vld_p1;
  assign hour = hour_p1;
  assign min  = min_p1;
  assign sec  = sec_p1;

  // A boundary is the tick that lands on second zero; matching uses the new
  // time while tick is high, so the FSM reacts on the following edge.
  assign bnd_p1 = vld_p1 & (sec_p1 == 6'd0);

  // Descending scan: the last assignment is the lowest matching slot.
  always_comb begin
    hit_p1 = 1'b0;
    win_p1 = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (slot_en[i] && (slot_hour[i] == hour_p1) && (slot_min[i] == min_p1)) begin
        hit_p1 = 1'b1;
        win_p1 = AW'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: ring FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      ring_cnt  <= '0;
      snz_cnt   <= '0;
      alarm_idx <= '0;
    end else begin
      state_r   <= state_nxt;
      ring_cnt  <= ring_nxt;
      snz_cnt   <= snz_nxt;
      alarm_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    ring_nxt  = ring_cnt;
    snz_nxt   = snz_cnt;
    idx_nxt   = alarm_idx;
    unique case (state_r)
      S_IDLE: begin
        if (bnd_p1 && hit_p1) begin
          state_nxt = S_RING;
          ring_nxt  = RING_LOAD;
          idx_nxt   = win_p1;
        end
      end
      S_RING: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (snooze) begin
          state_nxt = S_SNZ;
          snz_nxt   = SNZ_LOAD;
        end else if (bnd_p1) begin
          ring_nxt = dec_sat(ring_cnt);
          if (dec_sat(ring_cnt) == '0) begin
            state_nxt = S_IDLE;
          end
        end
      end
      S_SNZ: begin
        // Snooze pulses are deliberately ignored while already snoozed.
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (bnd_p1) begin
          snz_nxt = dec_sat(snz_cnt);
          if (dec_sat(snz_cnt) == '0) begin
            state_nxt = S_RING;
            ring_nxt  = RING_LOAD;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    alarm_on = (state_r == S_RING);
  end

  assign state = state_r;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// -----------------------------------------------------------------------------
// tb_multi_alarm_clock
//
// Directed bench for multi_alarm_clock with a 4-cycle time base (DIV = 4), so
// one tick every 4 clocks and one minute every 240 clocks. Every time write
// clears the prescaler, so the cycle counts below are measured from a write.
// -----------------------------------------------------------------------------
module tb_multi_alarm_clock;

  localparam int NA = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          set_valid;
  logic          set_ready;
  logic [AW-1:0] set_target;
  logic [4:0]    set_hour;
  logic [5:0]    set_min;
  logic          set_en;
  logic          set_err;
  logic          snooze;
  logic          stop;
  logic          tick;
  logic [4:0]    hour;
  logic [5:0]    min;
  logic [5:0]    sec;
  logic          alarm_on;
  logic [AW-1:0] alarm_idx;
  logic [1:0]    state;

  int n_chk  = 0;
  int n_fail = 0;

  multi_alarm_clock #(
    .CLK_FREQ  (4),
    .TICK_FREQ (1),
    .NUM_ALARMS(NA),
    .INIT_HOUR (0),
    .INIT_MIN  (0),
    .ALARM_HOUR(7),
    .ALARM_MIN (30),
    .SNOOZE_MIN(5),
    .RING_MIN  (10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .set_valid (set_valid),
    .set_ready (set_ready),
    .set_target(set_target),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .set_en    (set_en),
    .set_err   (set_err),
    .snooze    (snooze),
    .stop      (stop),
    .tick      (tick),
    .hour      (hour),
    .min       (min),
    .sec       (sec),
    .alarm_on  (alarm_on),
    .alarm_idx (alarm_idx),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] tgt, input logic [4:0] h,
                          input logic [5:0] m, input logic en);
    for (int k = 0; k < 8 && !set_ready; k++) step(1);
    set_valid  = 1'b1;
    set_target = tgt;
    set_hour   = h;
    set_min    = m;
    set_en     = en;
    step(1);
    set_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    n_chk++;
    if ({hour, min, sec} !== {5'd0, 6'd0, 6'd0}) begin
      $display("FAIL reset_time: got %0d:%0d:%0d expected 0:0:0", hour, min, sec); n_fail++;
    end
    n_chk++;
    if ({tick, set_err, alarm_on} !== 3'b000) begin
      $display("FAIL reset_pulses: got tick=%b err=%b on=%b expected 0 0 0", tick, set_err, alarm_on); n_fail++;
    end
    n_chk++;
    if (state !== 2'd0 || alarm_idx !== 3'd0) begin
      $display("FAIL reset_fsm: got state=%0d idx=%0d expected 0 0", state, alarm_idx); n_fail++;
    end
    n_chk++;
    if (set_ready !== 1'b1) begin
      $display("FAIL reset_ready: got %b expected 1", set_ready); n_fail++;
    end
    rst = 1'b0;
  endtask

  task automatic test_time_count;
    step(3);
    n_chk++;
    if (tick !== 1'b0 || set_ready !== 1'b0) begin
      $display("FAIL pre_tick: got tick=%b ready=%b expected 0 0", tick, set_ready); n_fail++;
    end
    step(1);
    n_chk++;
    if (tick !== 1'b1 || sec !== 6'd1) begin
      $display("FAIL first_tick: got tick=%b sec=%0d expected 1 1", tick, sec); n_fail++;
    end
    step(1);
    n_chk++;
    if (tick !== 1'b0) begin
      $display("FAIL tick_width: got %b expected 0", tick); n_fail++;
    end
    step(235);
    n_chk++;
    if ({tick, hour, min, sec} !== {1'b1, 5'd0, 6'd1, 6'd0}) begin
      $display("FAIL sixty_ticks: got tick=%b %0d:%0d:%0d expected 1 0:1:0", tick, hour, min, sec); n_fail++;
    end
    do_write(3'd4, 5'd23, 6'd59, 1'b0);
    step(236);
    n_chk++;
    if ({hour, min, sec} !== {5'd23, 6'd59, 6'd59}) begin
      $display("FAIL preload_235959: got %0d:%0d:%0d expected 23:59:59", hour, min, sec); n_fail++;
    end
    step(4);
    n_chk++;
    if ({tick, hour, min, sec} !== {1'b1, 5'd0, 6'd0, 6'd0}) begin
      $display("FAIL day_wrap: got tick=%b %0d:%0d:%0d expected 1 0:0:0", tick, hour, min, sec); n_fail++;
    end
  endtask

  task automatic test_alarm_basic;
    do_write(3'd4, 5'd7, 6'd29, 1'b0);
    n_chk++;
    if ({hour, min, sec} !== {5'd7, 6'd29, 6'd0}) begin
      $display("FAIL time_write: got %0d:%0d:%0d expected 7:29:0", hour, min, sec); n_fail++;
    end
    step(240);
    n_chk++;
    if ({tick, hour, min, sec, alarm_on} !== {1'b1, 5'd7, 6'd30, 6'd0, 1'b0}) begin
      $display("FAIL match_tick: got tick=%b %0d:%0d:%0d on=%b expected 1 7:30:0 0", tick, hour, min, sec, alarm_on); n_fail++;
    end
    step(1);
    n_chk++;
    if ({alarm_on, state, alarm_idx} !== {1'b1, 2'd1, 3'd0}) begin
      $display("FAIL ring_start: got on=%b state=%0d idx=%0d expected 1 1 0", alarm_on, state, alarm_idx); n_fail++;
    end
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    n_chk++;
    if (state !== 2'd0 || alarm_on !== 1'b0) begin
      $display("FAIL stop: got state=%0d on=%b expected 0 0", state, alarm_on); n_fail++;
    end
  endtask

  task automatic test_snooze;
    do_write(3'd4, 5'd7, 6'd29, 1'b0);
    step(241);
    snooze = 1'b1;
    step(1);
    snooze = 1'b0;
    n_chk++;
    if (state !== 2'd2 || alarm_on !== 1'b0) begin
      $display("FAIL snooze_enter: got state=%0d on=%b expected 2 0", state, alarm_on); n_fail++;
    end
    // Rewind to 07:29 so slot 0 matches again while snoozed.
    do_write(3'd4, 5'd7, 6'd29, 1'b0);
    step(241);
    n_chk++;
    if (state !== 2'd2) begin
      $display("FAIL match_in_snooze: got state=%0d expected 2", state); n_fail++;
    end
    step(959);
    n_chk++;
    if (state !== 2'd2 || min !== 6'd34 || tick !== 1'b1) begin
      $display("FAIL snooze_hold: got state=%0d min=%0d tick=%b expected 2 34 1", state, min, tick); n_fail++;
    end
    step(1);
    n_chk++;
    if (state !== 2'd1 || alarm_on !== 1'b1) begin
      $display("FAIL snooze_expire: got state=%0d on=%b expected 1 1", state, alarm_on); n_fail++;
    end
    snooze = 1'b1;
    stop   = 1'b1;
    step(1);
    snooze = 1'b0;
    stop   = 1'b0;
    n_chk++;
    if (state !== 2'd0) begin
      $display("FAIL stop_beats_snooze: got state=%0d expected 0", state); n_fail++;
    end
  endtask

  task automatic test_timeout;
    do_write(3'd4, 5'd7, 6'd29, 1'b0);
    step(241);
    n_chk++;
    if (state !== 2'd1) begin
      $display("FAIL timeout_ring: got state=%0d expected 1", state); n_fail++;
    end
    step(2160);
    n_chk++;
    if (state !== 2'd1 || min !== 6'd39) begin
      $display("FAIL timeout_nine: got state=%0d min=%0d expected 1 39", state, min); n_fail++;
    end
    step(240);
    n_chk++;
    if (state !== 2'd0 || alarm_on !== 1'b0 || min !== 6'd40) begin
      $display("FAIL timeout_ten: got state=%0d on=%b min=%0d expected 0 0 40", state, alarm_on, min); n_fail++;
    end
  endtask

  task automatic test_priority;
    do_write(3'd1, 5'd8, 6'd0, 1'b1);
    do_write(3'd3, 5'd8, 6'd0, 1'b1);
    do_write(3'd2, 5'd8, 6'd0, 1'b0);
    do_write(3'd4, 5'd7, 6'd59, 1'b0);
    step(241);
    n_chk++;
    if ({state, alarm_idx, alarm_on} !== {2'd1, 3'd1, 1'b1}) begin
      $display("FAIL priority: got state=%0d idx=%0d on=%b expected 1 1 1", state, alarm_idx, alarm_on); n_fail++;
    end
  endtask

  task automatic test_reset_mid_ring;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_chk++;
    if ({state, alarm_idx, alarm_on, tick, set_err} !== {2'd0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_mid_ring: got state=%0d idx=%0d on=%b tick=%b err=%b expected 0 0 0 0 0", state, alarm_idx, alarm_on, tick, set_err); n_fail++;
    end
    n_chk++;
    if ({hour, min, sec} !== {5'd0, 6'd0, 6'd0}) begin
      $display("FAIL reset_mid_ring_time: got %0d:%0d:%0d expected 0:0:0", hour, min, sec); n_fail++;
    end
  endtask

  task automatic test_disabled_slot;
    do_write(3'd2, 5'd8, 6'd0, 1'b0);
    do_write(3'd4, 5'd7, 6'd59, 1'b0);
    step(241);
    n_chk++;
    if (state !== 2'd0 || alarm_on !== 1'b0 || hour !== 5'd8) begin
      $display("FAIL disabled_slot: got state=%0d on=%b hour=%0d expected 0 0 8", state, alarm_on, hour); n_fail++;
    end
  endtask

  task automatic test_write_err;
    do_write(3'd4, 5'd10, 6'd20, 1'b0);
    do_write(3'd4, 5'd24, 6'd5, 1'b0);
    n_chk++;
    if (set_err !== 1'b1 || hour !== 5'd10 || min !== 6'd20) begin
      $display("FAIL bad_hour: got err=%b %0d:%0d expected 1 10:20", set_err, hour, min); n_fail++;
    end
    step(1);
    n_chk++;
    if (set_err !== 1'b0) begin
      $display("FAIL err_pulse: got %b expected 0", set_err); n_fail++;
    end
    do_write(3'd5, 5'd1, 6'd1, 1'b1);
    n_chk++;
    if (set_err !== 1'b1) begin
      $display("FAIL bad_target: got %b expected 1", set_err); n_fail++;
    end
    do_write(3'd0, 5'd3, 6'd60, 1'b1);
    n_chk++;
    if (set_err !== 1'b1 || hour !== 5'd10) begin
      $display("FAIL bad_min: got err=%b hour=%0d expected 1 10", set_err, hour); n_fail++;
    end
  endtask

  task automatic test_ready_hold;
    do_write(3'd4, 5'd10, 6'd20, 1'b0);
    step(3);
    n_chk++;
    if (set_ready !== 1'b0) begin
      $display("FAIL ready_low: got %b expected 0", set_ready); n_fail++;
    end
    set_valid  = 1'b1;
    set_target = 3'd4;
    set_hour   = 5'd12;
    set_min    = 6'd34;
    step(1);
    n_chk++;
    if (hour !== 5'd10 || tick !== 1'b1 || sec !== 6'd1) begin
      $display("FAIL hold_not_taken: got hour=%0d tick=%b sec=%0d expected 10 1 1", hour, tick, sec); n_fail++;
    end
    step(1);
    set_valid = 1'b0;
    n_chk++;
    if ({hour, min, sec} !== {5'd12, 6'd34, 6'd0}) begin
      $display("FAIL hold_taken: got %0d:%0d:%0d expected 12:34:0", hour, min, sec); n_fail++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    set_valid  = 1'b0;
    set_target = '0;
    set_hour   = '0;
    set_min    = '0;
    set_en     = 1'b0;
    snooze     = 1'b0;
    stop       = 1'b0;
    test_reset();
    test_time_count();
    test_alarm_basic();
    test_snooze();
    test_timeout();
    test_priority();
    test_reset_mid_ring();
    test_disabled_slot();
    test_write_err();
    test_ready_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
Name: multi_alarm_clock

Overview:
Parametrised successor to the single-alarm clock core. It holds an HH:MM:SS time-of-day counter driven by an internal prescaler, plus NUM_ALARMS independently programmable and enableable alarm slots. A ringing FSM adds snooze, stop and auto-timeout. Time and alarm slots are loaded through a valid/ready write port; the block sits between the button/debounce logic and the LED/display drivers of the chip top.

Parameters:
CLK_FREQ, 50_000_000, input clock frequency in Hz
TICK_FREQ, 1, time-base tick rate in Hz; DIV = CLK_FREQ/TICK_FREQ, with DIV >= 2
NUM_ALARMS, 4, number of alarm slots (1..8); AW = clog2(NUM_ALARMS+1)
INIT_HOUR, 0, reset hour
INIT_MIN, 0, reset minute
ALARM_HOUR, 7, reset hour of slot 0
ALARM_MIN, 30, reset minute of slot 0
SNOOZE_MIN, 5, snooze length in minute boundaries (>= 1)
RING_MIN, 10, ring timeout in minute boundaries (>= 1)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
set_valid  in  1  write request
set_ready  out  1  write accepted when set_valid & set_ready
set_target  in  AW  0..NUM_ALARMS-1 selects an alarm slot; NUM_ALARMS selects the time
set_hour  in  5  hour to load
set_min  in  6  minute to load
set_en  in  1  slot enable to load (ignored for time writes)
set_err  out  1  one-cycle pulse when a write is rejected
snooze  in  1  single-cycle pulse, already synchronised/debounced
stop  in  1  single-cycle pulse, already synchronised/debounced
tick  out  1  one-cycle pulse per time-base tick
hour  out  5  0..23
min  out  6  0..59
sec  out  6  0..59
alarm_on  out  1  high while RINGING
alarm_idx  out  AW  slot that caused the current or last ring
state  out  2  0=IDLE, 1=RINGING, 2=SNOOZED

Behaviour:
- All state is updated on the rising edge of clk. rst has priority over every other input.
- Reset values:
  - time INIT_HOUR:INIT_MIN:00; prescaler 0; tick=0; set_err=0; state IDLE; alarm_on=0; alarm_idx=0.
  - slot 0 = ALARM_HOUR:ALARM_MIN, enabled; all other slots 00:00, disabled.
- Prescaler:
  - counts 0..DIV-1 and wraps.
  - At the edge where count==DIV-1, sec increments; tick is registered high for exactly that following cycle, so tick=1 coincides with the new time on the outputs.
  - Wraps: sec 59->0 increments min; min 59->0 increments hour; 23:59:59 -> 00:00:00.
- Minute boundary: a tick whose new sec==0. Time writes never create a boundary.
- Write port:
  - set_ready = 0 in the cycle the prescaler is at DIV-1; 1 otherwise. Writes never collide with an increment.
  - On accept with set_hour>23, set_min>59 or set_target>NUM_ALARMS: no state change; set_err pulses on the next cycle.
  - Time write: loads hour/min, clears sec and the prescaler; takes effect on the next cycle.
  - Slot write: loads hour, min and enable; takes effect on the next cycle.
- Match: at a minute boundary, a slot matches if it is enabled and its hour/min equal the new time. Lowest matching index wins.
- FSM (registered; evaluated the cycle after the tick):
  - IDLE: on a match -> RINGING; alarm_idx = winner; ring counter = RING_MIN.
  - RINGING:
    - stop -> IDLE.
    - else snooze -> SNOOZED; snooze counter = SNOOZE_MIN.
    - else each minute boundary decrements the ring counter; reaching 0 -> IDLE (timeout).
  - SNOOZED:
    - stop -> IDLE.
    - each minute boundary decrements the snooze counter; reaching 0 -> RINGING with ring counter reloaded to RING_MIN.
    - snooze input is ignored.
  - Stop and snooze in the same cycle: stop wins.
  - New matches while RINGING or SNOOZED are ignored; they are not queued.
  - A stop, snooze or write in the same cycle as a boundary is applied together with it. Stop still forces IDLE.
  - Disabling or rewriting the active slot does not affect RINGING/SNOOZED.
- Outputs: alarm_on = (state==RINGING), registered; it rises one cycle after the matching tick.
- Reset asserted mid-ring or mid-snooze returns everything to reset values on the next edge.

Test Plan:
- DIV=4, reset -> 00:00:00; tick every 4th cycle; after 60 ticks min=1, sec=0. Preload 23:59:59, one tick -> 00:00:00.
- Write time 07:29 with sec cleared; after 60 ticks -> 07:30:00; alarm_on rises the cycle after that tick; alarm_idx=0; state=1.
- Slots 1 and 3 both set to 08:00 and enabled -> ring at 08:00 with alarm_idx=1. Slot 2 set to 08:00 but disabled -> no ring.
- Ringing, snooze pulse -> state=2, alarm_on=0; after 5 minute boundaries -> state=1 again. Snooze and stop in the same cycle -> IDLE.
- Ringing with no input -> IDLE after 10 boundaries. Match at 07:30 while SNOOZED -> ignored.
- Write hour=24 -> set_err pulse, time unchanged. set_valid held at prescaler count DIV-1 -> not accepted until the next cycle. rst mid-ring -> all outputs at reset values.
